cola_comandos_botones: RTL and testbench



---
 rtl/cola_comandos_botones_if.sv | 22 ++
 rtl/cola_comandos_botones.sv | 182 ++++++++++++++++++
 tb/tb_cola_comandos_botones.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cola_comandos_botones_if.sv
// Consumer-facing side of the button command queue.
//
// Signals:
//   leer       pop strobe, one cycle per pop (driven by the consumer)
//   comando    head code, 0 when the queue is empty
//   vacio      queue empty
//   lleno      queue full
//   desbordes  saturating count of dropped presses
//
// Modports:
//   master  the queue, which drives comando/vacio/lleno/desbordes
//   slave   the consumer, which drives leer
interface cola_comandos_botones_if;
    logic       leer;
    logic [2:0] comando;
    logic       vacio;
    logic       lleno;
    logic [7:0] desbordes;

    modport master (input leer, output comando, vacio, lleno, desbordes);
    modport slave  (output leer, input comando, vacio, lleno, desbordes);
endinterface

// File: rtl/cola_comandos_botones.sv
// Button command queue: the producer end of the direction stream that feeds
// the snake movement state machine. The five raw buttons are synchronized
// and debounced. Each press is encoded into a 3-bit code and buffered in a
// small FIFO that the consumer pops one code at a time.
//
// Codes: 0 none/empty, 1 up, 2 down, 3 left, 4 right, 5 pause.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   arriba     raw up button, asynchronous
//   abajo      raw down button, asynchronous
//   izquierda  raw left button, asynchronous
//   derecha    raw right button, asynchronous
//   pausa      raw pause button, asynchronous
//   bus        queue interface (master side): leer in;
//              comando, vacio, lleno, desbordes out
//
// Parameters:
//   DEPTH       FIFO entries, power of two, 2..16
//   DEB_CYCLES  consecutive stable cycles needed to accept a level change
//
// Optional build macro:
//   FILTRO_REPETIDOS_EN  drops a direction code that equals the most recently
//                        enqueued code. Pause is never filtered, and enqueuing
//                        a pause clears the memory of the last code.
module cola_comandos_botones #(
    parameter int DEPTH      = 4,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic arriba,
    input  logic abajo,
    input  logic izquierda,
    input  logic derecha,
    input  logic pausa,
    cola_comandos_botones_if.master bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_FIN   = CW'(DEB_CYCLES - 1);
    localparam logic [PW:0]   CNT_LLENO = (PW + 1)'(DEPTH);

    // Bit order: 0 arriba, 1 abajo, 2 izquierda, 3 derecha, 4 pausa
    logic [4:0]    boton_raw;
    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    estable;
    logic [4:0]    estable_d;
    logic [4:0]    armado;
    logic [1:0]    arranque;
    logic [CW-1:0] cnt_deb [5];
    logic [4:0]    evento;

    logic [2:0]    codigo;
    logic          repetido;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          descarte;

    logic [2:0]    mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [7:0]    desbordes;
    logic          vacio;
    logic          lleno;

    assign boton_raw = {pausa, derecha, izquierda, abajo, arriba};

    // Synchronizer, debounce and press arming.
    // A button only becomes armed once the synchronizer has been filled after
    // reset and the button is seen low. A button held through reset therefore
    // produces no press until it is released and pressed again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            estable   <= '0;
            estable_d <= '0;
            armado    <= '0;
            arranque  <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_deb[i] <= '0;
            end
        end else begin
            sync1     <= boton_raw;
            sync2     <= sync1;
            estable_d <= estable;
            arranque  <= {arranque[0], 1'b1};
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == estable[i]) begin
                    cnt_deb[i] <= '0;
                end else if (cnt_deb[i] == CNT_FIN) begin
                    estable[i] <= sync2[i];
                    cnt_deb[i] <= '0;
                end else begin
                    cnt_deb[i] <= cnt_deb[i] + 1'b1;
                end
                if (arranque[1] && !sync2[i] && !estable[i]) begin
                    armado[i] <= 1'b1;
                end
            end
        end
    end

    // One-cycle press events on the rising edge of the debounced level
    assign evento = estable & ~estable_d & armado;

    // Priority: pausa > arriba > abajo > izquierda > derecha.
    // Lower-priority events in the same cycle are simply lost.
    always_comb begin
        codigo = 3'd0;
        if (evento[4])      codigo = 3'd5;
        else if (evento[0]) codigo = 3'd1;
        else if (evento[1]) codigo = 3'd2;
        else if (evento[2]) codigo = 3'd3;
        else if (evento[3]) codigo = 3'd4;
    end

`ifdef FILTRO_REPETIDOS_EN
    // ultimo never holds 5, so a pause can never match and be filtered
    logic [2:0] ultimo;

    assign repetido = (codigo != 3'd0) && (codigo == ultimo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ultimo <= 3'd0;
        end else if (push) begin
            ultimo <= (codigo == 3'd5) ? 3'd0 : codigo;
        end
    end
`else
    assign repetido = 1'b0;
`endif

    assign vacio    = (count == '0);
    assign lleno    = (count == CNT_LLENO);
    assign push_req = (codigo != 3'd0) && !repetido;
    assign pop      = bus.leer && !vacio;
    // When full, a pop in the same cycle frees the slot the push needs
    assign push     = push_req && (!lleno || pop);
    assign descarte = push_req && lleno && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            desbordes <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 3'd0;
            end
        end else begin
            if (push) begin
                mem[tail] <= codigo;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (descarte && (desbordes != 8'hFF)) begin
                desbordes <= desbordes + 1'b1;
            end
        end
    end

    assign bus.comando   = vacio ? 3'd0 : mem[head];
    assign bus.vacio     = vacio;
    assign bus.lleno     = lleno;
    assign bus.desbordes = desbordes;

endmodule

// File: tb/tb_cola_comandos_botones.sv
module tb_cola_comandos_botones;

    localparam int DEPTH = 4;
    localparam int DEB   = 4;

    logic       clk;
    logic       rst;
    logic [4:0] btn;   // 0 arriba, 1 abajo, 2 izquierda, 3 derecha, 4 pausa

    int checks = 0;
    int errors = 0;

    logic [2:0] q[$];
    int         m_ovf = 0;
    logic [2:0] m_ultimo = 3'd0;

    cola_comandos_botones_if bus ();

    cola_comandos_botones #(
        .DEPTH      (DEPTH),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arriba    (btn[0]),
        .abajo     (btn[1]),
        .izquierda (btn[2]),
        .derecha   (btn[3]),
        .pausa     (btn[4]),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] code_of(input logic [4:0] mask);
        if (mask[4]) return 3'd5;
        if (mask[0]) return 3'd1;
        if (mask[1]) return 3'd2;
        if (mask[2]) return 3'd3;
        if (mask[3]) return 3'd4;
        return 3'd0;
    endfunction

    task automatic expect_push(input logic [2:0] code);
`ifdef FILTRO_REPETIDOS_EN
        if (code != 3'd5 && code == m_ultimo) return;
`endif
        if (q.size() < DEPTH) begin
            q.push_back(code);
            m_ultimo = (code == 3'd5) ? 3'd0 : code;
        end else if (m_ovf < 255) begin
            m_ovf++;
        end
    endtask

    task automatic press(input logic [4:0] mask);
        btn = mask;
        repeat (10) tick();
        btn = '0;
        repeat (10) tick();
        expect_push(code_of(mask));
    endtask

    task automatic pop_check(input string tag);
        logic [2:0] exp;
        @(negedge clk);
        exp = (q.size() > 0) ? q[0] : 3'd0;
        chk({tag, "_cmd"}, 8'(bus.comando), 8'(exp));
        chk({tag, "_vacio"}, 8'(bus.vacio), 8'(q.size() == 0));
        tick();
        bus.leer = 1'b1;
        tick();
        bus.leer = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH && q.size() > 0; i++) begin
            pop_check(tag);
        end
        @(negedge clk);
        chk({tag, "_empty_vacio"}, 8'(bus.vacio), 8'd1);
        chk({tag, "_empty_cmd"}, 8'(bus.comando), 8'd0);
        chk({tag, "_ovf"}, bus.desbordes, 8'(m_ovf));
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        btn      = '0;
        bus.leer = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // 1: idle after reset, leer on empty queue is harmless
        @(negedge clk);
        chk("rst_cmd", 8'(bus.comando), 8'd0);
        chk("rst_vacio", 8'(bus.vacio), 8'd1);
        chk("rst_lleno", 8'(bus.lleno), 8'd0);
        chk("rst_ovf", bus.desbordes, 8'd0);
        tick();
        bus.leer = 1'b1;
        tick();
        bus.leer = 1'b0;
        @(negedge clk);
        chk("idle_pop_cmd", 8'(bus.comando), 8'd0);
        chk("idle_pop_vacio", 8'(bus.vacio), 8'd1);
        chk("idle_pop_lleno", 8'(bus.lleno), 8'd0);
        chk("idle_pop_ovf", bus.desbordes, 8'd0);
        tick();

        // 2: exact latency 2 + DEB + 1 from raw edge
        btn[0] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("lat_early_vacio", 8'(bus.vacio), 8'd1);
        @(negedge clk);
        chk("lat_vacio", 8'(bus.vacio), 8'd0);
        chk("lat_cmd", 8'(bus.comando), 8'd1);
        tick();
        repeat (2) tick();
        btn[0] = 1'b0;
        repeat (10) tick();
        expect_push(3'd1);
        pop_check("up_pop");
        @(negedge clk);
        chk("up_after_pop_cmd", 8'(bus.comando), 8'd0);
        chk("up_after_pop_vacio", 8'(bus.vacio), 8'd1);
        tick();

        // pause clears the repeat memory so the bounce test sees a fresh arriba
        press(5'b10000);
        drain("pause_sep");

        // 3: bouncing input, then held
        for (int i = 0; i < 5; i++) begin
            btn[0] = 1'b1;
            repeat (2) tick();
            btn[0] = 1'b0;
            repeat (2) tick();
        end
        @(negedge clk);
        chk("bounce_vacio", 8'(bus.vacio), 8'd1);
        tick();
        press(5'b00001);
        drain("bounce");

        // 4: fill, overflow, ordered pops
        press(5'b01000);
        press(5'b00100);
        press(5'b00010);
        press(5'b00001);
        @(negedge clk);
        chk("fill_lleno", 8'(bus.lleno), 8'd1);
        tick();
        press(5'b10000);
        @(negedge clk);
        chk("ovf_count", bus.desbordes, 8'(m_ovf));
        chk("ovf_lleno", 8'(bus.lleno), 8'd1);
        tick();
        drain("order");

        // 5: push and pop in the same cycle while full
        press(5'b01000);
        press(5'b00100);
        press(5'b00010);
        press(5'b00001);
        btn = 5'b01000;
        repeat (6) @(posedge clk);
        #1;
        bus.leer = 1'b1;
        @(negedge clk);
        chk("same_head", 8'(bus.comando), 8'(q[0]));
        chk("same_lleno_before", 8'(bus.lleno), 8'd1);
        tick();
        bus.leer = 1'b0;
        void'(q.pop_front());
        q.push_back(3'd4);
        m_ultimo = 3'd4;
        @(negedge clk);
        chk("same_lleno_after", 8'(bus.lleno), 8'd1);
        chk("same_ovf", bus.desbordes, 8'(m_ovf));
        tick();
        repeat (3) tick();
        btn = '0;
        repeat (10) tick();
        drain("same_cycle");

        // 6: simultaneous presses, repeat handling
        press(5'b10010);
        drain("prio");
        press(5'b01000);
        press(5'b01000);
        drain("rep_pair");
        press(5'b10000);
        drain("rep_clear");
        press(5'b01000);
        press(5'b10000);
        press(5'b01000);
        drain("rep_seq");

        // 7: reset mid-operation with a button held through it
        press(5'b00100);
        btn[0] = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("midrst_vacio", 8'(bus.vacio), 8'd1);
        chk("midrst_cmd", 8'(bus.comando), 8'd0);
        chk("midrst_ovf", bus.desbordes, 8'd0);
        q.delete();
        m_ovf    = 0;
        m_ultimo = 3'd0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        chk("held_rst_vacio", 8'(bus.vacio), 8'd1);
        tick();
        btn[0] = 1'b0;
        repeat (10) tick();
        press(5'b00001);
        drain("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
